// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues in-order memory requests, tracks the PCs of
// requests in flight, and presents returned instructions through a small
// first-word-fall-through buffer. A redirect flushes the buffer and silently
// drains responses that belong to the abandoned path.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] next_PC,
  input  logic             PCsrc,
  output logic [WIDTH-1:0] PC,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready
);

  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW:0] LIMIT = (CNTW + 1)'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

  state_t r_state;
  state_t w_stateNext;

  logic [WIDTH-1:0] r_pc;
  logic [CNTW-1:0]  r_count;
  logic [CNTW-1:0]  r_outstanding;
  logic [CNTW-1:0]  r_drop;
  logic [WIDTH-1:0] r_bufData [DEPTH];
  logic [WIDTH-1:0] r_bufPc   [DEPTH];
  logic [WIDTH-1:0] r_pendPc  [DEPTH];
  logic [PTRW-1:0]  r_bufRd;
  logic [PTRW-1:0]  r_bufWr;
  logic [PTRW-1:0]  r_pendRd;
  logic [PTRW-1:0]  r_pendWr;

  logic [CNTW:0]    w_inflight;
  logic [CNTW-1:0]  w_dropLoad;
  logic             w_req;
  logic             w_rsp;
  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic             w_valid;

  function automatic logic [PTRW-1:0] nextPtr(input logic [PTRW-1:0] p);
    if (p == PTRW'(DEPTH - 1)) return '0;
    return p + PTRW'(1);
  endfunction

  // Requests plus buffered entries may never exceed the buffer size, so every
  // response is guaranteed a free slot. Responses with nothing in flight are ignored.
  assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
  assign w_rsp      = imem_rvalid && (r_outstanding != '0);
  assign w_push     = w_rsp && (r_drop == '0) && !PCsrc;
  assign w_valid    = (r_count != '0) && !PCsrc;
  assign w_pop      = w_valid && instr_ready;
  assign w_issue    = w_req && imem_gnt;
  assign w_dropLoad = r_outstanding - CNTW'(w_rsp);

  assign PC          = r_pc;
  assign imem_addr   = r_pc;
  assign imem_req    = w_req;
  assign instr_valid = w_valid;
  assign instr       = r_bufData[r_bufRd];
  assign instr_pc    = r_bufPc[r_bufRd];

  // Next-state and request decode; a redirect overrides everything else.
  always_comb begin
    w_stateNext = r_state;
    w_req       = 1'b0;
    case (r_state)
      BOOT:  w_stateNext = RUN;
      RUN:   w_req = (w_inflight < LIMIT);
      DRAIN: if (w_rsp && (r_drop == CNTW'(1))) w_stateNext = RUN;
      default: w_stateNext = BOOT;
    endcase
    if (PCsrc) begin
      w_req       = 1'b0;
      w_stateNext = (w_dropLoad != '0) ? DRAIN : RUN;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= BOOT;
    else     r_state <= w_stateNext;
  end

  // PC only moves on a granted request or a redirect; the upstream mux does the arithmetic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_pc <= RESET_PC;
    else if (PCsrc || w_issue)   r_pc <= next_PC;
  end

  // In-flight and to-be-discarded response counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= r_outstanding + CNTW'(w_issue) - CNTW'(w_rsp);
      if (PCsrc)                        r_drop <= w_dropLoad;
      else if (w_rsp && r_drop != '0)   r_drop <= r_drop - CNTW'(1);
    end
  end

  // Pending-PC FIFO pointers; the head always matches the oldest response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pendRd <= '0;
      r_pendWr <= '0;
    end else begin
      if (w_issue) r_pendWr <= nextPtr(r_pendWr);
      if (w_rsp)   r_pendRd <= nextPtr(r_pendRd);
    end
  end

  // Pending-PC FIFO storage needs no reset; it is only read while entries are live.
  always_ff @(posedge clk) begin
    if (w_issue) r_pendPc[r_pendWr] <= r_pc;
  end

  // Instruction buffer; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bufRd <= '0;
      r_bufWr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_bufData[i] <= '0;
        r_bufPc[i]   <= '0;
      end
    end else if (PCsrc) begin
      r_bufRd <= '0;
      r_bufWr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_bufData[r_bufWr] <= imem_rdata;
        r_bufPc[r_bufWr]   <= r_pendPc[r_pendRd];
        r_bufWr            <= nextPtr(r_bufWr);
      end
      if (w_pop) r_bufRd <= nextPtr(r_bufRd);
      r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
    end
  end

endmodule
